// File: rtl/leaf_port_bridge_pkg.sv
// Shared constants and helpers for the leaf-shell user-side port bridge.
package leaf_bridge_pkg;

    // Defaults shared with leaf_interface so both ends agree on channel shape.
    localparam int DEFAULT_PAYLOAD_BITS = 32;
    localparam int DEFAULT_FIFO_DEPTH   = 4;
    localparam int DEFAULT_CNT_BITS     = 16;

    // Channel packing of the status vectors: input channels take the low
    // slots, output channels follow directly after them.
    localparam int IN_SLOT_BASE = 0;

    // Fill level needs one extra bit so that "full" is distinguishable from "empty".
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int in_slot(input int k);
        return IN_SLOT_BASE + k;
    endfunction

    function automatic int out_slot(input int num_in, input int k);
        return IN_SLOT_BASE + num_in + k;
    endfunction

endpackage

// File: rtl/leaf_port_bridge_fifo.sv
// One bridge channel: elastic FIFO with freeze gate and saturating pop counter.
module leaf_port_fifo
    import leaf_bridge_pkg::*;
#(
    parameter int PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    parameter int CNT_BITS     = DEFAULT_CNT_BITS,
    localparam int PTR_W       = $clog2(FIFO_DEPTH),
    localparam int OCC_W       = count_width(FIFO_DEPTH)
) (
    input  logic                    clk_user,
    input  logic                    reset_n,
    input  logic                    push_vld,
    output logic                    push_ack,
    input  logic [PAYLOAD_BITS-1:0] push_data,
    output logic                    pop_vld,
    input  logic                    pop_ack,
    output logic [PAYLOAD_BITS-1:0] pop_data,
    input  logic                    freeze,
    input  logic                    cnt_clr,
    output logic [CNT_BITS-1:0]     xfer_cnt,
    output logic [OCC_W-1:0]        occupancy
);

    logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PAYLOAD_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]        count_q, count_d;
    logic [CNT_BITS-1:0]     xfer_cnt_q, xfer_cnt_d;
    logic                    freeze_q, freeze_d;
    logic                    push;
    logic                    pop;

    // Ready and valid come only from registered state, so there is no
    // combinational path from either side's valid to the other side.
    assign push_ack  = (count_q != OCC_W'(FIFO_DEPTH));
    assign pop_vld   = (count_q != '0) && !freeze_q;
    assign pop_data  = mem_q[rd_ptr_q];
    assign push      = push_vld && push_ack;
    assign pop       = pop_vld && pop_ack;
    assign xfer_cnt  = xfer_cnt_q;
    assign occupancy = count_q;

    // Next-state for pointers, fill level, freeze sample and pop counter.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        xfer_cnt_d = xfer_cnt_q;
        freeze_d   = freeze;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase

        // Clear wins over a same-cycle pop; the counter sticks at all-ones.
        if (cnt_clr)
            xfer_cnt_d = '0;
        else if (pop && (xfer_cnt_q != '1))
            xfer_cnt_d = xfer_cnt_q + CNT_BITS'(1);
    end

    // Storage write: only the slot under the write pointer changes.
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = push_data;
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk_user) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            xfer_cnt_q <= '0;
            freeze_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            xfer_cnt_q <= xfer_cnt_d;
            freeze_q   <= freeze_d;
        end
    end

    // Storage array is intentionally not reset; contents are gated by count.
    always_ff @(posedge clk_user) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/leaf_port_bridge.sv
// User-side port bridge: one elastic FIFO per leaf input and output channel.
module leaf_port_bridge
    import leaf_bridge_pkg::*;
#(
    parameter int PAYLOAD_BITS  = DEFAULT_PAYLOAD_BITS,
    parameter int NUM_IN_PORTS  = 6,
    parameter int NUM_OUT_PORTS = 7,
    parameter int FIFO_DEPTH    = DEFAULT_FIFO_DEPTH,
    parameter int CNT_BITS      = DEFAULT_CNT_BITS,
    localparam int NUM_CH       = NUM_IN_PORTS + NUM_OUT_PORTS,
    localparam int OCC_W        = count_width(FIFO_DEPTH)
) (
    input  logic                                  clk_user,
    input  logic                                  reset_n,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  din_leaf_interface2user,
    input  logic [NUM_IN_PORTS-1:0]               vld_interface2user,
    output logic [NUM_IN_PORTS-1:0]               ack_user2interface,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user,
    output logic [NUM_IN_PORTS-1:0]               vld_bridge2user,
    input  logic [NUM_IN_PORTS-1:0]               ack_user2bridge,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]              vld_user2bridge,
    output logic [NUM_OUT_PORTS-1:0]              ack_bridge2user,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] dout_leaf_user2interface,
    output logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
    input  logic                                  freeze,
    input  logic                                  cnt_clr,
    output logic [NUM_CH*CNT_BITS-1:0]            xfer_cnt,
    output logic [NUM_CH*OCC_W-1:0]               occupancy
);

    // Interface-to-kernel channels: leaf_interface pushes, kernel pops.
    for (genvar k = 0; k < NUM_IN_PORTS; k++) begin : g_in
        localparam int SLOT = in_slot(k);
        leaf_port_fifo #(
            .PAYLOAD_BITS (PAYLOAD_BITS),
            .FIFO_DEPTH   (FIFO_DEPTH),
            .CNT_BITS     (CNT_BITS)
        ) u_fifo (
            .clk_user  (clk_user),
            .reset_n   (reset_n),
            .push_vld  (vld_interface2user[k]),
            .push_ack  (ack_user2interface[k]),
            .push_data (din_leaf_interface2user[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .pop_vld   (vld_bridge2user[k]),
            .pop_ack   (ack_user2bridge[k]),
            .pop_data  (dout_leaf_interface2user[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .freeze    (freeze),
            .cnt_clr   (cnt_clr),
            .xfer_cnt  (xfer_cnt[SLOT*CNT_BITS +: CNT_BITS]),
            .occupancy (occupancy[SLOT*OCC_W +: OCC_W])
        );
    end

    // Kernel-to-interface channels: kernel pushes, leaf_interface pops.
    for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : g_out
        localparam int SLOT = out_slot(NUM_IN_PORTS, k);
        leaf_port_fifo #(
            .PAYLOAD_BITS (PAYLOAD_BITS),
            .FIFO_DEPTH   (FIFO_DEPTH),
            .CNT_BITS     (CNT_BITS)
        ) u_fifo (
            .clk_user  (clk_user),
            .reset_n   (reset_n),
            .push_vld  (vld_user2bridge[k]),
            .push_ack  (ack_bridge2user[k]),
            .push_data (din_leaf_user2interface[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .pop_vld   (vld_user2interface[k]),
            .pop_ack   (ack_interface2user[k]),
            .pop_data  (dout_leaf_user2interface[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .freeze    (freeze),
            .cnt_clr   (cnt_clr),
            .xfer_cnt  (xfer_cnt[SLOT*CNT_BITS +: CNT_BITS]),
            .occupancy (occupancy[SLOT*OCC_W +: OCC_W])
        );
    end

endmodule

// File: tb/tb_leaf_port_bridge.sv
// Self-checking bench for leaf_port_bridge against a queue-based channel model.
module tb_leaf_port_bridge;

    localparam int N  = 6;
    localparam int M  = 7;
    localparam int C  = N + M;
    localparam int P  = 32;
    localparam int D  = 4;
    localparam int CB = 4;
    localparam int OW = 3;
    localparam int CNT_MAX = (1 << CB) - 1;

    logic clk_user = 1'b0;
    always #5 clk_user = ~clk_user;

    logic           reset_n;
    logic           freeze;
    logic           cnt_clr;
    logic [N*P-1:0] din_i2u, dout_i2u;
    logic [N-1:0]   vld_i2u, ack_u2i, vld_b2u, ack_u2b;
    logic [M*P-1:0] din_u2i, dout_u2i;
    logic [M-1:0]   vld_u2b, ack_b2u, vld_u2if, ack_if2u;
    logic [C*CB-1:0] xfer_cnt;
    logic [C*OW-1:0] occupancy;

    // Channel-indexed views: channel c < N is input channel c, else output channel c-N.
    logic           push_vld   [C];
    logic [P-1:0]   push_data  [C];
    logic           pop_ack    [C];
    logic           push_ack_o [C];
    logic           pop_vld_o  [C];
    logic [P-1:0]   pop_data_o [C];
    logic [CB-1:0]  cnt_o      [C];
    logic [OW-1:0]  occ_o      [C];

    for (genvar c = 0; c < N; c++) begin : g_in_map
        assign vld_i2u[c]          = push_vld[c];
        assign din_i2u[c*P +: P]   = push_data[c];
        assign ack_u2b[c]          = pop_ack[c];
        assign push_ack_o[c]       = ack_u2i[c];
        assign pop_vld_o[c]        = vld_b2u[c];
        assign pop_data_o[c]       = dout_i2u[c*P +: P];
    end
    for (genvar c = 0; c < M; c++) begin : g_out_map
        assign vld_u2b[c]          = push_vld[N+c];
        assign din_u2i[c*P +: P]   = push_data[N+c];
        assign ack_if2u[c]         = pop_ack[N+c];
        assign push_ack_o[N+c]     = ack_b2u[c];
        assign pop_vld_o[N+c]      = vld_u2if[c];
        assign pop_data_o[N+c]     = dout_u2i[c*P +: P];
    end
    for (genvar c = 0; c < C; c++) begin : g_stat_map
        assign cnt_o[c] = xfer_cnt[c*CB +: CB];
        assign occ_o[c] = occupancy[c*OW +: OW];
    end

    leaf_port_bridge #(
        .PAYLOAD_BITS  (P),
        .NUM_IN_PORTS  (N),
        .NUM_OUT_PORTS (M),
        .FIFO_DEPTH    (D),
        .CNT_BITS      (CB)
    ) dut (
        .clk_user                 (clk_user),
        .reset_n                  (reset_n),
        .din_leaf_interface2user  (din_i2u),
        .vld_interface2user       (vld_i2u),
        .ack_user2interface       (ack_u2i),
        .dout_leaf_interface2user (dout_i2u),
        .vld_bridge2user          (vld_b2u),
        .ack_user2bridge          (ack_u2b),
        .din_leaf_user2interface  (din_u2i),
        .vld_user2bridge          (vld_u2b),
        .ack_bridge2user          (ack_b2u),
        .dout_leaf_user2interface (dout_u2i),
        .vld_user2interface       (vld_u2if),
        .ack_interface2user       (ack_if2u),
        .freeze                   (freeze),
        .cnt_clr                  (cnt_clr),
        .xfer_cnt                 (xfer_cnt),
        .occupancy                (occupancy)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: each channel is an ordered list of buffered words.
    logic [P-1:0] mq [C][$];
    int           mcnt [C];
    bit           mfrz;

    function automatic bit exp_vld(input int c);
        return (mq[c].size() != 0) && !mfrz;
    endfunction

    function automatic bit exp_ack(input int c);
        return mq[c].size() != D;
    endfunction

    // Apply the transfer rules for the upcoming edge using the current inputs.
    task automatic model_step();
        bit do_push [C];
        bit do_pop  [C];
        for (int c = 0; c < C; c++) begin
            do_pop[c]  = exp_vld(c) && pop_ack[c];
            do_push[c] = push_vld[c] && exp_ack(c);
        end
        if (!reset_n) begin
            for (int c = 0; c < C; c++) begin
                mq[c].delete();
                mcnt[c] = 0;
            end
            mfrz = 1'b0;
        end else begin
            for (int c = 0; c < C; c++) begin
                if (do_pop[c]) void'(mq[c].pop_front());
                if (do_push[c]) mq[c].push_back(push_data[c]);
                if (cnt_clr) mcnt[c] = 0;
                else if (do_pop[c] && mcnt[c] < CNT_MAX) mcnt[c] = mcnt[c] + 1;
            end
            mfrz = freeze;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_user);
        @(negedge clk_user);
    endtask

    task automatic set_idle();
        for (int c = 0; c < C; c++) begin
            push_vld[c]  = 1'b0;
            push_data[c] = '0;
            pop_ack[c]   = 1'b0;
        end
        freeze  = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        reset_n = 1'b0;
        tick();
        tick();
        for (int c = 0; c < C; c++) begin
            vectors++;
            if (pop_vld_o[c] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_vld ch%0d: got %b expected 0", c, pop_vld_o[c]);
            end
            vectors++;
            if (push_ack_o[c] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_ack ch%0d: got %b expected 1", c, push_ack_o[c]);
            end
            vectors++;
            if (occ_o[c] !== '0 || cnt_o[c] !== '0) begin
                miscompares++;
                $display("FAIL reset_stat ch%0d: got occ %0d cnt %0d expected 0 0", c, occ_o[c], cnt_o[c]);
            end
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_word();
        set_idle();
        pop_ack[0]   = 1'b1;
        push_vld[0]  = 1'b1;
        push_data[0] = 32'hDEADBEEF;
        tick();
        push_vld[0] = 1'b0;
        vectors++;
        if (pop_vld_o[0] !== 1'b1 || pop_data_o[0] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL single_word: got vld %b data %h expected 1 deadbeef", pop_vld_o[0], pop_data_o[0]);
        end
        tick();
        vectors++;
        if (cnt_o[0] !== CB'(1) || pop_vld_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL single_word_cnt: got cnt %0d vld %b expected 1 0", cnt_o[0], pop_vld_o[0]);
        end
    endtask

    task automatic test_backpressure();
        int c;
        int got;
        logic [P-1:0] w [5];
        c = N + 2;
        w[0] = 32'hA000_0001; w[1] = 32'hA000_0002; w[2] = 32'hA000_0003;
        w[3] = 32'hA000_0004; w[4] = 32'hA000_0005;
        set_idle();
        for (int i = 0; i < 4; i++) begin
            push_vld[c]  = 1'b1;
            push_data[c] = w[i];
            tick();
        end
        vectors++;
        if (push_ack_o[c] !== 1'b0 || occ_o[c] !== OW'(4)) begin
            miscompares++;
            $display("FAIL bp_full: got ack %b occ %0d expected 0 4", push_ack_o[c], occ_o[c]);
        end
        push_data[c] = w[4];
        tick();
        vectors++;
        if (push_ack_o[c] !== 1'b0 || occ_o[c] !== OW'(4)) begin
            miscompares++;
            $display("FAIL bp_hold: got ack %b occ %0d expected 0 4", push_ack_o[c], occ_o[c]);
        end
        pop_ack[c] = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc == 1) begin
                vectors++;
                if (push_ack_o[c] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bp_fifth_accept: got ack %b expected 1", push_ack_o[c]);
                end
            end
            if (pop_vld_o[c] === 1'b1 && got < 5) begin
                vectors++;
                if (pop_data_o[c] !== w[got]) begin
                    miscompares++;
                    $display("FAIL bp_order word%0d: got %h expected %h", got, pop_data_o[c], w[got]);
                end
                got++;
            end
            tick();
            if (cyc == 1) push_vld[c] = 1'b0;
        end
        vectors++;
        if (got != 5 || occ_o[c] !== '0) begin
            miscompares++;
            $display("FAIL bp_count: got %0d words occ %0d expected 5 0", got, occ_o[c]);
        end
    endtask

    task automatic test_freeze();
        set_idle();
        for (int c = 0; c < C; c++) pop_ack[c] = 1'b1;
        for (int f = 0; f < 26; f++) begin
            freeze = (f >= 4 && f < 14);
            for (int c = 0; c < C; c++) begin
                push_vld[c]  = (f < 14);
                push_data[c] = $urandom;
            end
            for (int c = 0; c < C; c++) begin
                vectors++;
                if (pop_vld_o[c] !== exp_vld(c)) begin
                    miscompares++;
                    $display("FAIL freeze_vld f%0d ch%0d: got %b expected %b", f, c, pop_vld_o[c], exp_vld(c));
                end
                if (f >= 5 && f <= 14) begin
                    vectors++;
                    if (pop_vld_o[c] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL freeze_hold f%0d ch%0d: got %b expected 0", f, c, pop_vld_o[c]);
                    end
                end
                if (exp_vld(c)) begin
                    vectors++;
                    if (pop_data_o[c] !== mq[c][0]) begin
                        miscompares++;
                        $display("FAIL freeze_data f%0d ch%0d: got %h expected %h", f, c, pop_data_o[c], mq[c][0]);
                    end
                end
                if (f == 14) begin
                    vectors++;
                    if (occ_o[c] !== OW'(D)) begin
                        miscompares++;
                        $display("FAIL freeze_fill ch%0d: got %0d expected %0d", c, occ_o[c], D);
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_counter_saturation();
        set_idle();
        cnt_clr = 1'b1;
        tick();
        cnt_clr    = 1'b0;
        pop_ack[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push_vld[0]  = 1'b1;
            push_data[0] = $urandom;
            tick();
        end
        push_vld[0] = 1'b0;
        tick();
        tick();
        vectors++;
        if (cnt_o[0] !== CB'(CNT_MAX) || occ_o[0] !== '0) begin
            miscompares++;
            $display("FAIL cnt_saturate: got cnt %0d occ %0d expected %0d 0", cnt_o[0], occ_o[0], CNT_MAX);
        end
        push_vld[0] = 1'b1;
        tick();
        push_vld[0] = 1'b0;
        cnt_clr     = 1'b1;
        tick();
        cnt_clr = 1'b0;
        vectors++;
        if (cnt_o[0] !== '0 || occ_o[0] !== '0) begin
            miscompares++;
            $display("FAIL cnt_clr_vs_pop: got cnt %0d occ %0d expected 0 0", cnt_o[0], occ_o[0]);
        end
    endtask

    task automatic test_reset_midstream();
        set_idle();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < C; c++) begin
                push_vld[c]  = 1'b1;
                push_data[c] = $urandom;
            end
            tick();
        end
        set_idle();
        for (int c = 0; c < C; c++) begin
            vectors++;
            if (occ_o[c] !== OW'(2)) begin
                miscompares++;
                $display("FAIL mid_half ch%0d: got %0d expected 2", c, occ_o[c]);
            end
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < C; c++) begin
            vectors++;
            if (pop_vld_o[c] !== 1'b0 || push_ack_o[c] !== 1'b1 || occ_o[c] !== '0) begin
                miscompares++;
                $display("FAIL mid_reset ch%0d: got vld %b ack %b occ %0d expected 0 1 0",
                         c, pop_vld_o[c], push_ack_o[c], occ_o[c]);
            end
        end
        push_vld[N]  = 1'b1;
        push_data[N] = 32'h5A5A_0F0F;
        pop_ack[N]   = 1'b1;
        tick();
        push_vld[N] = 1'b0;
        vectors++;
        if (pop_vld_o[N] !== 1'b1 || pop_data_o[N] !== 32'h5A5A_0F0F) begin
            miscompares++;
            $display("FAIL mid_first_word: got vld %b data %h expected 1 5a5a0f0f", pop_vld_o[N], pop_data_o[N]);
        end
        tick();
    endtask

    task automatic test_random_soak();
        bit window;
        int wpos;
        set_idle();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            wpos    = cyc % 100;
            window  = (wpos >= 40 && wpos < 60);
            freeze  = ((cyc % 500) >= 480 && (cyc % 500) < 490);
            cnt_clr = ($urandom_range(0, 299) == 0);
            for (int c = 0; c < C; c++) begin
                push_vld[c]  = window ? 1'b1 : ($urandom_range(0, 9) < 7);
                push_data[c] = $urandom;
                pop_ack[c]   = window ? 1'b1 : ($urandom_range(0, 9) < 6);
            end
            for (int c = 0; c < C; c++) begin
                vectors++;
                if (pop_vld_o[c] !== exp_vld(c) || push_ack_o[c] !== exp_ack(c)) begin
                    miscompares++;
                    $display("FAIL soak_hs cyc%0d ch%0d: got vld %b ack %b expected %b %b",
                             cyc, c, pop_vld_o[c], push_ack_o[c], exp_vld(c), exp_ack(c));
                end
                if (exp_vld(c)) begin
                    vectors++;
                    if (pop_data_o[c] !== mq[c][0]) begin
                        miscompares++;
                        $display("FAIL soak_data cyc%0d ch%0d: got %h expected %h", cyc, c, pop_data_o[c], mq[c][0]);
                    end
                end
                vectors++;
                if (occ_o[c] !== OW'(mq[c].size()) || cnt_o[c] !== CB'(mcnt[c])) begin
                    miscompares++;
                    $display("FAIL soak_stat cyc%0d ch%0d: got occ %0d cnt %0d expected %0d %0d",
                             cyc, c, occ_o[c], cnt_o[c], mq[c].size(), mcnt[c]);
                end
                if (window && wpos >= 42) begin
                    vectors++;
                    if (pop_vld_o[c] !== 1'b1 || push_ack_o[c] !== 1'b1) begin
                        miscompares++;
                        $display("FAIL soak_throughput cyc%0d ch%0d: got vld %b ack %b expected 1 1",
                                 cyc, c, pop_vld_o[c], push_ack_o[c]);
                    end
                end
            end
            tick();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        reset_n = 1'b0;
        mfrz    = 1'b0;
        for (int c = 0; c < C; c++) mcnt[c] = 0;
        @(negedge clk_user);
        test_reset();
        test_single_word();
        test_backpressure();
        test_freeze();
        test_counter_saturation();
        test_reset_midstream();
        test_random_soak();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
